// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID and generation timestamp from a sysid
// slave, compares both against build-time constants and records the result.
// Checks run on a start request or, optionally, periodically from IDLE.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1389208005,
  parameter int unsigned RECHECK_PERIOD     = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [7:0]  mismatch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    CMP   = 2'd3
  } state_t;

  // Counter only needs to reach RECHECK_PERIOD-1.
  localparam int unsigned CW = (RECHECK_PERIOD > 1) ? $clog2(RECHECK_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((RECHECK_PERIOD == 0) ? 0 : (RECHECK_PERIOD - 1));

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] recheck_cnt;
  logic [CW-1:0] recheck_cnt_next;
  logic          trigger;
  logic          launch;
  logic          addr_next;
  logic          id_eq;
  logic          ts_eq;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: fixed one-cycle-per-state walk once launched.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch) state_next = RD_ID;
      RD_ID:   state_next = RD_TS;
      RD_TS:   state_next = CMP;
      CMP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath decode from the current state.
  always_comb begin
    trigger          = (RECHECK_PERIOD != 0) && (state == IDLE) && (recheck_cnt == CNT_LAST);
    launch           = (state == IDLE) && (start || trigger);
    busy             = (state != IDLE);
    done             = (state == CMP);
    addr_next        = (state_next == RD_TS);
    id_eq            = (captured_id == EXPECTED_ID);
    ts_eq            = (sysid_readdata == EXPECTED_TIMESTAMP);
    recheck_cnt_next = '0;
    if (RECHECK_PERIOD != 0 && state == IDLE && !launch)
      recheck_cnt_next = recheck_cnt + 1'b1;
  end

  // Registered outputs and captures. The comparison is evaluated on the edge
  // entering CMP (timestamp taken straight off the bus) so that flags,
  // captures and the mismatch count are already valid during the done cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sysid_address  <= 1'b0;
      recheck_cnt    <= '0;
      captured_id    <= '0;
      captured_ts    <= '0;
      id_ok          <= 1'b0;
      ts_ok          <= 1'b0;
      match          <= 1'b0;
      valid          <= 1'b0;
      mismatch_count <= '0;
    end else begin
      sysid_address <= addr_next;
      recheck_cnt   <= recheck_cnt_next;
      if (state == RD_ID)
        captured_id <= sysid_readdata;
      if (state == RD_TS) begin
        captured_ts <= sysid_readdata;
        id_ok       <= id_eq;
        ts_ok       <= ts_eq;
        match       <= id_eq && ts_eq;
        valid       <= 1'b1;
        if (!(id_eq && ts_eq) && (mismatch_count != '1))
          mismatch_count <= mismatch_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Testbench for sysid_checker: directed scenarios plus randomized checks
// scored against a transaction-level model of the expected results.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID   = 32'd0;
  localparam logic [31:0] EXP_TS   = 32'd1389208005;
  localparam logic [31:0] B_EXP_ID = 32'hC0FF_EE01;
  localparam logic [31:0] B_EXP_TS = 32'h1234_5678;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int mm_model = 0;

  // DUT A: default parameters, driven by the directed/random tests.
  logic        reset_n, start, sysid_address;
  logic [31:0] sysid_readdata, slv_id, slv_ts;
  logic        busy, done, valid, id_ok, ts_ok, match;
  logic [31:0] captured_id, captured_ts;
  logic [7:0]  mismatch_count;

  assign sysid_readdata = sysid_address ? slv_ts : slv_id;

  sysid_checker dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .sysid_address(sysid_address), .sysid_readdata(sysid_readdata),
    .busy(busy), .done(done), .valid(valid),
    .id_ok(id_ok), .ts_ok(ts_ok), .match(match),
    .captured_id(captured_id), .captured_ts(captured_ts),
    .mismatch_count(mismatch_count)
  );

  // DUT B: custom constants and periodic re-check.
  logic        reset_n_b, start_b, addr_b;
  logic [31:0] rdata_b;
  logic        busy_b, done_b, valid_b, id_ok_b, ts_ok_b, match_b;
  logic [31:0] cap_id_b, cap_ts_b;
  logic [7:0]  mm_b;

  assign rdata_b = addr_b ? B_EXP_TS : B_EXP_ID;

  sysid_checker #(
    .EXPECTED_ID(B_EXP_ID),
    .EXPECTED_TIMESTAMP(B_EXP_TS),
    .RECHECK_PERIOD(4)
  ) dut_b (
    .clock(clock), .reset_n(reset_n_b), .start(start_b),
    .sysid_address(addr_b), .sysid_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .valid(valid_b),
    .id_ok(id_ok_b), .ts_ok(ts_ok_b), .match(match_b),
    .captured_id(cap_id_b), .captured_ts(cap_ts_b),
    .mismatch_count(mm_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stimulus only: launch one check and report cycles from start to done.
  task automatic run_one(input logic [31:0] id, input logic [31:0] ts, output int lat);
    int t0;
    slv_id = id;
    slv_ts = ts;
    start  = 1'b1;
    t0     = cyc;
    tick();
    start  = 1'b0;
    lat    = -1;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sysid_address, busy, done, valid, id_ok, ts_ok, match} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000000",
               {sysid_address, busy, done, valid, id_ok, ts_ok, match});
    end
    checks++;
    if ({captured_id, captured_ts, mismatch_count} !== 72'd0) begin
      errors++;
      $display("FAIL reset_data got id=%h ts=%h mm=%0d want 0", captured_id, captured_ts, mismatch_count);
    end
    reset_n  = 1'b1;
    mm_model = 0;
    tick();
  endtask

  task automatic test_basic();
    int c;
    slv_id = EXP_ID;
    slv_ts = EXP_TS;
    start  = 1'b1;
    c      = cyc;
    tick();
    start  = 1'b0;
    checks++;
    if (sysid_address !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_rd_id cyc=%0d addr=%b busy=%b want addr=0 busy=1", cyc - c, sysid_address, busy);
    end
    tick();
    checks++;
    if (sysid_address !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_ts addr=%b busy=%b done=%b want 1 1 0", sysid_address, busy, done);
    end
    tick();
    checks++;
    if ({sysid_address, done, match, id_ok, ts_ok, valid, busy} !== 7'b0111111) begin
      errors++;
      $display("FAIL basic_cmp got=%b want=0111111", {sysid_address, done, match, id_ok, ts_ok, valid, busy});
    end
    checks++;
    if (mismatch_count !== 8'd0 || captured_ts !== EXP_TS) begin
      errors++;
      $display("FAIL basic_data mm=%0d ts=%0d want mm=0 ts=%0d", mismatch_count, captured_ts, EXP_TS);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b1 || match !== 1'b1) begin
      errors++;
      $display("FAIL basic_after done=%b busy=%b valid=%b match=%b want 0 0 1 1", done, busy, valid, match);
    end
  endtask

  task automatic test_ts_mismatch();
    int lat;
    run_one(EXP_ID, 32'd1389208006, lat);
    mm_model++;
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL tsmm_latency got=%0d want=3", lat);
    end
    checks++;
    if ({id_ok, ts_ok, match} !== 3'b100 || captured_ts !== 32'd1389208006 || mismatch_count !== 8'(mm_model)) begin
      errors++;
      $display("FAIL tsmm_result flags=%b ts=%0d mm=%0d want 100 1389208006 %0d",
               {id_ok, ts_ok, match}, captured_ts, mismatch_count, mm_model);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c, ndone, dcyc;
    slv_id = EXP_ID;
    slv_ts = EXP_TS;
    ndone  = 0;
    dcyc   = -1;
    start  = 1'b1;
    c      = cyc;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        dcyc = cyc - c;
      end
      if (i <= 3) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy offset=%0d got=%b want=1", i, busy);
        end
      end
    end
    checks++;
    if (ndone !== 1 || dcyc !== 3) begin
      errors++;
      $display("FAIL b2b_done count=%0d at=%0d want count=1 at=3", ndone, dcyc);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] id, ts;
    logic e_id, e_ts;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      id   = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      ts   = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      e_id = (id == EXP_ID);
      e_ts = (ts == EXP_TS);
      if (!(e_id && e_ts) && mm_model < 255) mm_model++;
      run_one(id, ts, lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL rand_latency n=%0d got=%0d want=3", n, lat);
      end
      checks++;
      if ({id_ok, ts_ok, match, valid} !== {e_id, e_ts, e_id && e_ts, 1'b1}) begin
        errors++;
        $display("FAIL rand_flags n=%0d got=%b want=%b", n, {id_ok, ts_ok, match, valid},
                 {e_id, e_ts, e_id && e_ts, 1'b1});
      end
      checks++;
      if (captured_id !== id || captured_ts !== ts || mismatch_count !== 8'(mm_model)) begin
        errors++;
        $display("FAIL rand_data n=%0d id=%h ts=%h mm=%0d want %h %h %0d", n,
                 captured_id, captured_ts, mismatch_count, id, ts, mm_model);
      end
      slv_id = ~id;
      slv_ts = ~ts;
      tick();
      checks++;
      if (done !== 1'b0 || captured_id !== id || captured_ts !== ts || match !== (e_id && e_ts)) begin
        errors++;
        $display("FAIL rand_hold n=%0d done=%b id=%h ts=%h want done=0 %h %h", n, done, captured_id, captured_ts, id, ts);
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    for (int n = 0; n < 300; n++) begin
      run_one(EXP_ID, EXP_TS ^ 32'd1, lat);
      if (mm_model < 255) mm_model++;
      checks++;
      if (lat !== 3 || mismatch_count !== 8'(mm_model)) begin
        errors++;
        $display("FAIL sat_count n=%0d lat=%0d mm=%0d want lat=3 mm=%0d", n, lat, mismatch_count, mm_model);
      end
      tick();
    end
    checks++;
    if (mismatch_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final got=%0d want=255", mismatch_count);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    slv_id = EXP_ID;
    slv_ts = EXP_TS;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    // Now in RD_TS: assert reset together with a start request.
    reset_n = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    mm_model = 0;
    checks++;
    if ({sysid_address, busy, done, valid, id_ok, ts_ok, match} !== 7'b0 ||
        {captured_id, captured_ts, mismatch_count} !== 72'd0) begin
      errors++;
      $display("FAIL abort_reset flags=%b mm=%0d want all zero",
               {sysid_address, busy, done, valid, id_ok, ts_ok, match}, mismatch_count);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b done=%b want 0 0", busy, done);
    end
    run_one(EXP_ID, EXP_TS, lat);
    checks++;
    if (lat !== 3 || match !== 1'b1 || valid !== 1'b1 || mismatch_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_restart lat=%0d match=%b valid=%b mm=%0d want 3 1 1 0", lat, match, valid, mismatch_count);
    end
    tick();
  endtask

  task automatic test_recheck();
    int r, ndone, k;
    tick();
    reset_n_b = 1'b1;
    r     = cyc;
    ndone = 0;
    for (int i = 1; i <= 36; i++) begin
      tick();
      // Coincide a start with the second periodic trigger.
      start_b = (cyc - r == 10);
      if (done_b === 1'b1) begin
        k = 6 + 7 * ndone;
        checks++;
        if (cyc - r !== k || match_b !== 1'b1 || cap_id_b !== B_EXP_ID || cap_ts_b !== B_EXP_TS) begin
          errors++;
          $display("FAIL recheck_done at=%0d want=%0d match=%b id=%h ts=%h", cyc - r, k, match_b, cap_id_b, cap_ts_b);
        end
        ndone++;
      end
    end
    start_b = 1'b0;
    checks++;
    if (ndone !== 5 || mm_b !== 8'd0 || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL recheck_count got=%0d mm=%0d valid=%b want 5 0 1", ndone, mm_b, valid_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    reset_n_b = 1'b0;
    start_b   = 1'b0;
    slv_id    = EXP_ID;
    slv_ts    = EXP_TS;
    test_reset();
    test_basic();
    test_ts_mismatch();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_abort();
    test_recheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
